// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage feeding the control unit. Holds the program counter, drives the
//   instruction-memory address and captures the returned word into the IF/ID
//   instruction register. The register is split into decode fields for the
//   control unit and the register file.
//
//   Ports:
//     clk, rst      clock / synchronous active-high reset
//     imem_addr     instruction-memory byte address (the fetch PC)
//     imem_data     instruction word read combinationally from imem_addr
//     stall         hold PC, IR and valid this cycle
//     pc_load       redirect: load pc_target (word aligned), flush IR
//     pc_target     redirect address, bits [1:0] forced to zero
//     PC, IR        address and word of the captured instruction
//     valid         IR holds a real instruction
//     halted        fetch has stopped on HALT_INSTR
//     OP, Funct3, Funct7, RA1, RA2, WA   slices of IR
module instr_fetch_unit #(
  parameter int unsigned          PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [31:0]          HALT_INSTR = 32'h00000073
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                stall,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_target,
  output logic [PC_WIDTH-1:0] PC,
  output logic [31:0]         IR,
  output logic                valid,
  output logic                halted,
  output logic [6:0]          OP,
  output logic [2:0]          Funct3,
  output logic [6:0]          Funct7,
  output logic [4:0]          RA1,
  output logic [4:0]          RA2,
  output logic [4:0]          WA
);

  localparam logic [31:0]         NOP        = 32'h00000013;
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                valid_q, valid_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      ir_q       <= NOP;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    valid_d    = valid_q;
    unique case (state_q)
      // One dead cycle so memory sees a settled address before the first capture.
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (pc_load) begin
          fetch_pc_d = pc_target & ALIGN_MASK;
          ir_d       = NOP;
          valid_d    = 1'b0;
        end else if (!stall) begin
          ir_d    = imem_data;
          pc_d    = fetch_pc_q;
          valid_d = 1'b1;
          // The halt word is captured but the fetch address stays on it.
          if (imem_data == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end
        end
      end
      ST_HALT: valid_d = 1'b0;
      default: state_d = ST_BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    imem_addr = fetch_pc_q;
    PC        = pc_q;
    IR        = ir_q;
    valid     = valid_q;
    halted    = (state_q == ST_HALT);
    OP        = ir_q[6:0];
    WA        = ir_q[11:7];
    Funct3    = ir_q[14:12];
    RA1       = ir_q[19:15];
    RA2       = ir_q[24:20];
    Funct7    = ir_q[31:25];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_target = '0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [7:0]  PC;
  logic [31:0] IR;
  logic        valid, halted;
  logic [6:0]  OP, Funct7;
  logic [2:0]  Funct3;
  logic [4:0]  RA1, RA2, WA;

  logic [31:0] mem [0:63];
  int tests = 0;
  int fails = 0;

  // Reference model: architectural view of the fetch stage
  int unsigned m_fetch, m_pc;
  logic [31:0] m_ir;
  bit m_valid, m_halted, m_boot;

  assign imem_data = mem[imem_addr[7:2]];

  instr_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00), .HALT_INSTR(32'h00000073)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .pc_load(pc_load), .pc_target(pc_target),
    .PC(PC), .IR(IR), .valid(valid), .halted(halted),
    .OP(OP), .Funct3(Funct3), .Funct7(Funct7), .RA1(RA1), .RA2(RA2), .WA(WA)
  );

  always #5 clk = ~clk;

  wire [49:0] dut_vec = {imem_addr, PC, IR, valid, halted};
  wire [31:0] dut_fields = {Funct7, RA2, RA1, Funct3, WA, OP};

  function automatic logic [49:0] exp_vec();
    return {m_fetch[7:0], m_pc[7:0], m_ir, m_valid, m_halted};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'h100;
    return w;
  endfunction

  // Apply inputs for one cycle, advance the model, and land 1ns after the edge.
  task automatic cycle(input bit r, input bit s, input bit l, input logic [7:0] t);
    logic [31:0] w;
    rst = r; stall = s; pc_load = l; pc_target = t;
    if (r) begin
      m_fetch = 0; m_pc = 0; m_ir = NOP; m_valid = 0; m_halted = 0; m_boot = 1;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (l) begin
      m_fetch = int'(t) / 4 * 4;
      m_ir = NOP; m_valid = 0;
    end else if (!s) begin
      w = mem[m_fetch / 4];
      m_ir = w; m_pc = m_fetch; m_valid = 1;
      if (w == HALT) m_halted = 1;
      else m_fetch = (m_fetch + 4) % 256;
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
  endtask

  task automatic test_reset();
    fill_mem();
    cycle(1, 1, 1, 8'h55);
    tests++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL reset_state got %h want %h", dut_vec, exp_vec());
    end
    tests++;
    if (dut_fields !== NOP) begin
      fails++; $display("FAIL reset_fields got %h want %h", dut_fields, NOP);
    end
  endtask

  task automatic test_basic();
    fill_mem();
    mem[0] = 32'h00000033; mem[1] = 32'h40000033;
    cycle(1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      cycle(0, 0, 0, 0);
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL basic_c%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    tests++;
    if (OP !== 7'b0110011 || Funct7 !== 7'b0100000 || PC !== 8'h04) begin
      fails++; $display("FAIL basic_sub_decode got op=%b f7=%b pc=%h want op=0110011 f7=0100000 pc=04", OP, Funct7, PC);
    end
  endtask

  task automatic test_stall();
    fill_mem();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      cycle(0, 1, 0, 0);
      tests++;
      if (dut_vec !== exp_vec() || PC !== 8'h00 || imem_addr !== 8'h04) begin
        fails++; $display("FAIL stall_hold_c%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    for (int c = 0; c < 2; c++) begin
      cycle(0, 0, 0, 0);
      tests++;
      if (dut_vec !== exp_vec() || IR !== mem[c + 1]) begin
        fails++; $display("FAIL stall_resume_c%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_redirect();
    fill_mem();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 8'h21);
    tests++;
    if (dut_vec !== exp_vec() || imem_addr !== 8'h20 || IR !== NOP || valid !== 1'b0) begin
      fails++; $display("FAIL redirect_bubble got %h want %h", dut_vec, exp_vec());
    end
    cycle(0, 0, 0, 0);
    tests++;
    if (dut_vec !== exp_vec() || IR !== mem[8] || PC !== 8'h20 || valid !== 1'b1) begin
      fails++; $display("FAIL redirect_target got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_wrap();
    fill_mem();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 8'hF8);
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0, 0, 0);
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL wrap_c%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
    tests++;
    if (PC !== 8'h04 || IR !== mem[1]) begin
      fails++; $display("FAIL wrap_after got pc=%h ir=%h want pc=04 ir=%h", PC, IR, mem[1]);
    end
  endtask

  task automatic test_halt();
    fill_mem();
    mem[2] = HALT;
    cycle(1, 0, 0, 0);
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0);
    tests++;
    if (dut_vec !== exp_vec() || IR !== HALT || PC !== 8'h08 || valid !== 1'b1 || halted !== 1'b1) begin
      fails++; $display("FAIL halt_capture got %h want %h", dut_vec, exp_vec());
    end
    for (int c = 0; c < 5; c++) begin
      cycle(0, 1'($urandom), 1'($urandom), 8'($urandom));
      tests++;
      if (dut_vec !== exp_vec() || imem_addr !== 8'h08 || valid !== 1'b0) begin
        fails++; $display("FAIL halt_hold_c%0d got %h want %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    // Starts from the halted state left by test_halt.
    cycle(1, 0, 1, 8'h40);
    tests++;
    if (dut_vec !== {8'h00, 8'h00, NOP, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_from_halt got %h want %h", dut_vec, {8'h00, 8'h00, NOP, 1'b0, 1'b0});
    end
    mem[2] = rand_word();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 8'h30);
    cycle(1, 1, 1, 8'h30);
    tests++;
    if (dut_vec !== exp_vec() || valid !== 1'b0) begin
      fails++; $display("FAIL reset_mid_redirect got %h want %h", dut_vec, exp_vec());
    end
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    tests++;
    if (dut_vec !== exp_vec() || PC !== 8'h00 || IR !== mem[0]) begin
      fails++; $display("FAIL reset_refetch got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int errs = 0;
    fill_mem();
    mem[$urandom_range(63)] = HALT;
    cycle(1, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(99) < 3, $urandom_range(99) < 25, $urandom_range(99) < 10, 8'($urandom));
      tests++;
      if (dut_vec !== exp_vec() || dut_fields !== m_ir) begin
        fails++;
        if (errs < 10) $display("FAIL random_c%0d got %h/%h want %h/%h", c, dut_vec, dut_fields, exp_vec(), m_ir);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
